// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
// Holds the frame-control state encoding, default widths and the
// power-of-two test used when config point checking is built in.
package fft_pkg;

  localparam int FFT_PTS_W  = 12;
  localparam int FFT_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } fft_state_e;

  // True when v has exactly one bit set.
  function automatic logic is_pow2(input logic [31:0] v);
    is_pow2 = (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fft_inflight_cnt.sv
// Occupancy tracker for frames inside the FFT core.
// occ counts frames whose sink eop was accepted but whose source eop
// has not yet been seen; full blocks new frame starts. Also keeps the
// wrapping frames_in / frames_out event counters.
module fft_inflight_cnt
  import fft_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sink_eop,
  input  logic             source_eop,
  output logic             full,
  output logic [CNT_W-1:0] frames_in,
  output logic [CNT_W-1:0] frames_out
);

  localparam int OCC_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(MAX_INFLIGHT);

  logic [OCC_W-1:0] occ_r;
  logic [CNT_W-1:0] frames_in_r;
  logic [CNT_W-1:0] frames_out_r;

  // Up/down occupancy; simultaneous in and out events cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (sink_eop && !source_eop) begin
      if (occ_r != OCC_MAX) begin
        occ_r <= occ_r + OCC_W'(1);
      end
    end else if (!sink_eop && source_eop) begin
      if (occ_r != {OCC_W{1'b0}}) begin
        occ_r <= occ_r - OCC_W'(1);
      end
    end
  end

  // Wrapping frame event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_in_r  <= {CNT_W{1'b0}};
      frames_out_r <= {CNT_W{1'b0}};
    end else begin
      if (sink_eop) begin
        frames_in_r <= frames_in_r + CNT_W'(1);
      end
      if (source_eop) begin
        frames_out_r <= frames_out_r + CNT_W'(1);
      end
    end
  end

  assign full       = (occ_r >= OCC_MAX);
  assign frames_in  = frames_in_r;
  assign frames_out = frames_out_r;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of a variable-size streaming FFT core.
// Frames an unframed sample stream with sop/eop, holds point count and
// direction stable per frame, throttles frame starts on core occupancy
// and latches core error reports.
// Build option: define FFT_FRAME_CTRL_PTS_CHECK_EN to reject configs whose
// point count is not a power of two within [MIN_PTS, MAX_PTS].
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_W       = FFT_DATA_W,
  parameter int PTS_W        = FFT_PTS_W,
  parameter int MIN_PTS      = 64,
  parameter int MAX_PTS      = 2048,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [PTS_W-1:0]  cfg_pts,
  input  logic              cfg_inverse,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              fft_sink_valid,
  input  logic              fft_sink_ready,
  output logic              fft_sink_sop,
  output logic              fft_sink_eop,
  output logic [DATA_W-1:0] fft_sink_real,
  output logic [DATA_W-1:0] fft_sink_imag,
  output logic [1:0]        fft_sink_error,
  output logic [PTS_W-1:0]  fft_fftpts_in,
  output logic              fft_inverse,
  input  logic              fft_source_valid,
  input  logic              fft_source_ready,
  input  logic              fft_source_eop,
  input  logic [1:0]        fft_source_error,
  input  logic              err_clr,
  output logic              err_sticky,
  output logic [15:0]       frames_in,
  output logic [15:0]       frames_out
);

  fft_state_e       state_r;
  fft_state_e       state_nxt_s;

  logic             pend_valid_r;
  logic [PTS_W-1:0] pend_pts_r;
  logic             pend_inv_r;
  logic             act_valid_r;
  logic [PTS_W-1:0] act_pts_r;
  logic             act_inv_r;
  logic [PTS_W-1:0] cnt_r;
  logic             err_sticky_r;

  logic             run_s;
  logic             beat_s;
  logic             last_s;
  logic             start_ok_s;
  logic             start_s;
  logic             cfg_hs_s;
  logic             pts_ok_s;
  logic             cfg_take_s;
  logic             sink_eop_acc_s;
  logic             src_eop_acc_s;
  logic             src_err_s;
  logic             full_s;

  assign run_s          = (state_r == ST_RUN);
  assign beat_s         = run_s && in_valid && fft_sink_ready;
  // Modulo-2^PTS_W compare: pts=0 yields a 2^PTS_W-beat frame.
  assign last_s         = (cnt_r == (act_pts_r - PTS_W'(1)));
  assign sink_eop_acc_s = beat_s && last_s;
  assign src_eop_acc_s  = fft_source_valid && fft_source_ready && fft_source_eop;
  assign src_err_s      = fft_source_valid && fft_source_ready && (fft_source_error != 2'b00);
  assign start_ok_s     = run_en && !err_sticky_r && !full_s && (pend_valid_r || act_valid_r);
  assign cfg_hs_s       = cfg_valid && !pend_valid_r;
  assign cfg_take_s     = cfg_hs_s && pts_ok_s;

`ifdef FFT_FRAME_CTRL_PTS_CHECK_EN
  logic cfg_err_r;

  assign pts_ok_s = is_pow2(32'(cfg_pts)) &&
                    (32'(cfg_pts) >= 32'(MIN_PTS)) &&
                    (32'(cfg_pts) <= 32'(MAX_PTS));

  // One-cycle pulse after an illegal config has been consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_hs_s && !pts_ok_s;
    end
  end

  assign cfg_err = cfg_err_r;
`else
  logic cfg_unused_s;

  assign pts_ok_s     = 1'b1;
  assign cfg_unused_s = (MIN_PTS > 0);
  assign cfg_err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and frame-start decision.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_WAIT: begin
        if (start_ok_s) begin
          start_s     = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (pend_valid_r || act_valid_r) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sink_eop_acc_s) begin
          if (pend_valid_r || act_valid_r) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // One-deep pending config slot; filled by handshake, drained at frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_r <= 1'b0;
      pend_pts_r   <= {PTS_W{1'b0}};
      pend_inv_r   <= 1'b0;
    end else if (cfg_take_s) begin
      pend_valid_r <= 1'b1;
      pend_pts_r   <= cfg_pts;
      pend_inv_r   <= cfg_inverse;
    end else if (start_s && pend_valid_r) begin
      pend_valid_r <= 1'b0;
    end
  end

  // Active config only changes at a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_valid_r <= 1'b0;
      act_pts_r   <= PTS_W'(MAX_PTS);
      act_inv_r   <= 1'b0;
    end else if (start_s && pend_valid_r) begin
      act_valid_r <= 1'b1;
      act_pts_r   <= pend_pts_r;
      act_inv_r   <= pend_inv_r;
    end
  end

  // Beat counter within the current frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {PTS_W{1'b0}};
    end else if (start_s) begin
      cnt_r <= {PTS_W{1'b0}};
    end else if (beat_s) begin
      cnt_r <= cnt_r + PTS_W'(1);
    end
  end

  // Sticky core error; clear has priority over a same-cycle set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky_r <= 1'b0;
    end else if (err_clr) begin
      err_sticky_r <= 1'b0;
    end else if (src_err_s) begin
      err_sticky_r <= 1'b1;
    end
  end

  fft_inflight_cnt #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (16)
  ) u_inflight (
    .clk        (clk),
    .reset_n    (reset_n),
    .sink_eop   (sink_eop_acc_s),
    .source_eop (src_eop_acc_s),
    .full       (full_s),
    .frames_in  (frames_in),
    .frames_out (frames_out)
  );

  assign cfg_ready      = !pend_valid_r;
  assign in_ready       = run_s && fft_sink_ready;
  assign fft_sink_valid = run_s && in_valid;
  assign fft_sink_sop   = run_s && (cnt_r == {PTS_W{1'b0}});
  assign fft_sink_eop   = run_s && last_s;
  assign fft_sink_real  = in_real;
  assign fft_sink_imag  = in_imag;
  assign fft_sink_error = 2'b00;
  assign fft_fftpts_in  = act_pts_r;
  assign fft_inverse    = act_inv_r;
  assign err_sticky     = err_sticky_r;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: framing, config hand-over,
// in-flight throttling, error latching and config checking.
module tb_fft_frame_ctrl;

  logic        clk;
  logic        reset_n;
  logic        run_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [11:0] cfg_pts;
  logic        cfg_inverse;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_real;
  logic [15:0] in_imag;
  logic        fft_sink_valid;
  logic        fft_sink_ready;
  logic        fft_sink_sop;
  logic        fft_sink_eop;
  logic [15:0] fft_sink_real;
  logic [15:0] fft_sink_imag;
  logic [1:0]  fft_sink_error;
  logic [11:0] fft_fftpts_in;
  logic        fft_inverse;
  logic        fft_source_valid;
  logic        fft_source_ready;
  logic        fft_source_eop;
  logic [1:0]  fft_source_error;
  logic        err_clr;
  logic        err_sticky;
  logic [15:0] frames_in;
  logic [15:0] frames_out;

  int tests = 0;
  int fails = 0;
  int exp_in = 0;
  int exp_out = 0;

  fft_frame_ctrl dut (
    .clk(clk), .reset_n(reset_n), .run_en(run_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pts(cfg_pts),
    .cfg_inverse(cfg_inverse), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .fft_sink_valid(fft_sink_valid), .fft_sink_ready(fft_sink_ready),
    .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
    .fft_sink_real(fft_sink_real), .fft_sink_imag(fft_sink_imag),
    .fft_sink_error(fft_sink_error), .fft_fftpts_in(fft_fftpts_in),
    .fft_inverse(fft_inverse), .fft_source_valid(fft_source_valid),
    .fft_source_ready(fft_source_ready), .fft_source_eop(fft_source_eop),
    .fft_source_error(fft_source_error), .err_clr(err_clr),
    .err_sticky(err_sticky), .frames_in(frames_in), .frames_out(frames_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_cfg(input logic [11:0] p, input logic inv);
    int w;
    w = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_pts = p; cfg_inverse = inv;
    #1;
    while (!cfg_ready && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("cfg_accept", 32'(w < 200), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_src_eop();
    @(negedge clk);
    fft_source_valid = 1'b1; fft_source_ready = 1'b1; fft_source_eop = 1'b1;
    @(negedge clk);
    fft_source_valid = 1'b0; fft_source_ready = 1'b0; fft_source_eop = 1'b0;
    exp_out++;
  endtask

  // Offer samples for n cycles; nothing may be accepted.
  task automatic block_check(input string name, input int n);
    int seen;
    seen = 0;
    @(negedge clk);
    in_valid = 1'b1; fft_sink_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (in_ready || fft_sink_valid) seen++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check(name, 32'(seen), 32'd0);
  endtask

  // Stream one frame of n beats, checking framing and pass-through on each accepted beat.
  task automatic stream(input string name, input int n, input logic [11:0] ep, input logic ei,
                        input bit rnd, input bit stop, input bit src_last);
    int beats, bad, cyc;
    beats = 0; bad = 0; cyc = 0;
    while (beats < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b1;
      in_real  = 16'(beats);
      in_imag  = ~16'(beats);
      fft_sink_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beats == n - 1) begin
        if (stop) run_en = 1'b0;
        if (src_last) begin
          fft_source_valid = 1'b1; fft_source_ready = 1'b1; fft_source_eop = 1'b1;
        end
      end
      #1;
      if (in_ready) begin
        if (fft_sink_sop !== (beats == 0) || fft_sink_eop !== (beats == n - 1) ||
            fft_fftpts_in !== ep || fft_inverse !== ei || fft_sink_valid !== 1'b1 ||
            fft_sink_real !== 16'(beats) || fft_sink_imag !== ~16'(beats))
          bad++;
        beats++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; fft_sink_ready = 1'b1;
    if (src_last) begin
      fft_source_valid = 1'b0; fft_source_ready = 1'b0; fft_source_eop = 1'b0;
      exp_out++;
    end
    exp_in++;
    check({name, "_beats"}, 32'(beats), 32'(n));
    check({name, "_framing"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [11:0] pts;
    logic        inv;
    bit          rnd;
    int          exp_frames_in;
  } frame_vec_t;

  frame_vec_t vecs[3];

  initial begin
    vecs[0] = '{pts: 12'd512,  inv: 1'b1, rnd: 1'b1, exp_frames_in: 7};
    vecs[1] = '{pts: 12'd64,   inv: 1'b0, rnd: 1'b1, exp_frames_in: 8};
    vecs[2] = '{pts: 12'd2048, inv: 1'b1, rnd: 1'b0, exp_frames_in: 9};

    reset_n = 1'b0; run_en = 1'b0; cfg_valid = 1'b0; cfg_pts = 12'd0; cfg_inverse = 1'b0;
    in_valid = 1'b0; in_real = 16'd0; in_imag = 16'd0; fft_sink_ready = 1'b1;
    fft_source_valid = 1'b0; fft_source_ready = 1'b0; fft_source_eop = 1'b0;
    fft_source_error = 2'b00; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_fftpts_held", 32'(fft_fftpts_in), 32'd2048);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sink_valid", 32'(fft_sink_valid), 32'd0);
    check("rst_sop_eop", 32'({fft_sink_sop, fft_sink_eop}), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_frames", 32'({frames_in, frames_out}), 32'd0);
    check("rst_fftpts", 32'(fft_fftpts_in), 32'd2048);
    check("rst_inverse", 32'(fft_inverse), 32'd0);
    check("rst_sink_error", 32'(fft_sink_error), 32'd0);

    // Basic 64-point frame.
    send_cfg(12'd64, 1'b0);
    run_en = 1'b1;
    stream("f64", 64, 12'd64, 1'b0, 1'b0, 1'b0, 1'b0);
    check("f64_frames_in", 32'(frames_in), 32'(exp_in));
    pulse_src_eop();
    check("f64_frames_out", 32'(frames_out), 32'(exp_out));

    // New config written mid-frame applies only to the next frame.
    fork
      stream("mid64", 64, 12'd64, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (20) @(negedge clk);
        send_cfg(12'd128, 1'b1);
      end
    join
    stream("next128", 128, 12'd128, 1'b1, 1'b0, 1'b0, 1'b0);
    check("two_frames_in", 32'(frames_in), 32'(exp_in));

    // Two frames in flight: the third start is held until a source eop.
    block_check("full_blocks", 20);
    pulse_src_eop();
    stream("after_drain", 128, 12'd128, 1'b1, 1'b0, 1'b0, 1'b1);
    check("same_cycle_in", 32'(frames_in), 32'(exp_in));
    check("same_cycle_out", 32'(frames_out), 32'(exp_out));
    stream("refill", 128, 12'd128, 1'b1, 1'b0, 1'b0, 1'b0);
    block_check("full_again", 20);
    run_en = 1'b0;
    pulse_src_eop();
    pulse_src_eop();
    check("drained_out", 32'(frames_out), 32'(exp_out));

    // 256-point frame with a randomly stalling sink.
    send_cfg(12'd256, 1'b0);
    run_en = 1'b1;
    stream("rnd256", 256, 12'd256, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_src_eop();

    // Table of config/frame vectors.
    for (int i = 0; i < 3; i++) begin
      send_cfg(vecs[i].pts, vecs[i].inv);
      run_en = 1'b1;
      stream("vec", int'(vecs[i].pts == 12'd0 ? 4096 : vecs[i].pts), vecs[i].pts,
             vecs[i].inv, vecs[i].rnd, 1'b1, 1'b0);
      check("vec_frames_in", 32'(frames_in), 32'(vecs[i].exp_frames_in));
      pulse_src_eop();
      check("vec_frames_out", 32'(frames_out), 32'(vecs[i].exp_frames_in));
    end

    // Core error mid-frame: frame completes, then starts are blocked.
    run_en = 1'b1;
    fork
      stream("err_frame", 2048, 12'd2048, 1'b1, 1'b0, 1'b0, 1'b0);
      begin
        repeat (30) @(negedge clk);
        fft_source_valid = 1'b1; fft_source_ready = 1'b1; fft_source_error = 2'b01;
        @(negedge clk);
        fft_source_valid = 1'b0; fft_source_ready = 1'b0; fft_source_error = 2'b00;
      end
    join
    #1;
    check("err_set", 32'(err_sticky), 32'd1);
    block_check("err_blocks", 20);
    // Clear and a fresh error in the same cycle: clear wins.
    @(negedge clk);
    err_clr = 1'b1; fft_source_valid = 1'b1; fft_source_ready = 1'b1; fft_source_error = 2'b10;
    @(negedge clk);
    err_clr = 1'b0; fft_source_valid = 1'b0; fft_source_ready = 1'b0; fft_source_error = 2'b00;
    #1;
    check("err_clr_wins", 32'(err_sticky), 32'd0);
    stream("resume", 2048, 12'd2048, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_src_eop();
    pulse_src_eop();
    check("resume_frames_out", 32'(frames_out), 32'(exp_out));

`ifdef FFT_FRAME_CTRL_PTS_CHECK_EN
    // Illegal point count is consumed, flagged and not stored.
    send_cfg(12'd100, 1'b0);
    #1;
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    check("cfg_not_stored", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    #1;
    check("cfg_err_clears", 32'(cfg_err), 32'd0);
    run_en = 1'b1;
    stream("pts_kept", 2048, 12'd2048, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_src_eop();
`else
    // Single-beat frames.
    send_cfg(12'd1, 1'b0);
    #1;
    check("cfg_err_tied", 32'(cfg_err), 32'd0);
    run_en = 1'b1;
    stream("one_a", 1, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    stream("one_b", 1, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_en = 1'b0;
    pulse_src_eop();
    pulse_src_eop();
`endif
    check("final_frames_in", 32'(frames_in), 32'(exp_in));
    check("final_frames_out", 32'(frames_out), 32'(exp_out));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
